// File: rtl/mem_op_pkg.sv
// Shared types, opcode constants and control-word decode
// for the load/store sequencing controller.
package mem_op_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4,
    S_T5, S_T6, S_T7, S_DONE, S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    K_LD, K_LDI, K_ST, K_ILL
  } kind_t;

  localparam int OPC_LD  = 0;
  localparam int OPC_LDI = 1;
  localparam int OPC_ST  = 2;

  localparam logic [1:0] MDR_BUS = 2'b00;
  localparam logic [1:0] MDR_MEM = 2'b01;
  localparam logic [1:0] MDR_IMM = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'd2;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in;
    logic mdr_in, mdr_out, read, write;
    logic ir_in, y_in, zlow_in, zlow_out;
    logic gra, grb, r_in, r_out;
    logic ba_out, c_out;
    logic [1:0] mdr_read;
    logic [3:0] alu_op;
    logic busy, done, illegal, fault;
  } ctl_t;

  function automatic ctl_t ctl_decode(
    input state_t s,
    input kind_t  k,
    input logic   first
  );
    ctl_t c;
    c = '0;
    c.busy = (s != S_IDLE) && (s != S_FAULT);
    unique case (s)
      S_T0: begin
        c.pc_out  = 1'b1;
        c.mar_in  = 1'b1;
        c.inc_pc  = 1'b1;
        c.zlow_in = 1'b1;
      end
      S_T1: begin
        c.zlow_out = 1'b1;
        c.pc_in    = first;
        c.read     = 1'b1;
        c.mdr_in   = 1'b1;
        c.mdr_read = MDR_MEM;
      end
      S_T2: begin
        c.mdr_out = 1'b1;
        c.ir_in   = 1'b1;
      end
      S_T3: begin
        c.grb    = 1'b1;
        c.ba_out = 1'b1;
        c.y_in   = 1'b1;
      end
      S_T4: begin
        c.c_out   = 1'b1;
        c.alu_op  = ALU_ADD;
        c.zlow_in = 1'b1;
      end
      S_T5: begin
        c.zlow_out = 1'b1;
        c.gra      = (k == K_LDI);
        c.r_in     = (k == K_LDI);
        c.mar_in   = (k != K_LDI);
      end
      S_T6: begin
        c.mdr_in = 1'b1;
        if (k == K_ST) begin
          c.gra      = 1'b1;
          c.r_out    = 1'b1;
          c.mdr_read = MDR_BUS;
        end else begin
          c.read     = 1'b1;
          c.mdr_read = MDR_MEM;
        end
      end
      S_T7: begin
        c.write   = (k == K_ST);
        c.mdr_out = (k != K_ST);
        c.gra     = (k != K_ST);
        c.r_in    = (k != K_ST);
      end
      S_DONE: begin
        c.done    = 1'b1;
        c.illegal = (k == K_ILL);
      end
      S_FAULT: c.fault = 1'b1;
      default: c.busy = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles; expired flags the cycle
// on which one more miss would reach WAIT_MAX.
module mem_wait_timer
  import mem_op_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(WAIT_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mem_op_control.sv
// Load/store instruction sequencer: T0..T7 microsteps
// with memory wait handling and a sticky timeout fault.
module mem_op_control
  import mem_op_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic              mem_ready,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              MDRin,
  output logic              MDRout,
  output logic              read,
  output logic              write,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zlowout,
  output logic              Gra,
  output logic              Grb,
  output logic              Grc,
  output logic              Rin,
  output logic              Rout,
  output logic              BAout,
  output logic              Cout,
  output logic [1:0]        mdr_read,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              fault
);

  localparam logic [OPC_W-1:0] OP_LD  = OPC_W'(OPC_LD);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(OPC_LDI);
  localparam logic [OPC_W-1:0] OP_ST  = OPC_W'(OPC_ST);

  state_t state, state_d;
  kind_t  kind, kind_d;
  ctl_t   ctl_q;

  logic             first_d;
  logic             in_wait;
  logic             wt_clear;
  logic             wt_en;
  logic             expired;
  logic [OPC_W-1:0] opc;
  logic             unused_ir;

  assign opc       = ir[DATA_W-1 -: OPC_W];
  assign unused_ir = ^ir[DATA_W-OPC_W-1:0];

  assign in_wait = (state == S_T1)
                || (state == S_T6 && kind == K_LD)
                || (state == S_T7 && kind == K_ST);
  assign wt_clear = !in_wait;
  assign wt_en    = in_wait && !mem_ready;

  mem_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (wt_clear),
    .enable (wt_en),
    .expired(expired)
  );

  always_comb begin
    state_d = state;
    kind_d  = kind;
    unique case (state)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (mem_ready)    state_d = S_T2;
        else if (expired) state_d = S_FAULT;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        unique case (1'b1)
          (opc == OP_LD): begin
            kind_d  = K_LD;
            state_d = S_T4;
          end
          (opc == OP_LDI): begin
            kind_d  = K_LDI;
            state_d = S_T4;
          end
          (opc == OP_ST): begin
            kind_d  = K_ST;
            state_d = S_T4;
          end
          default: begin
            kind_d  = K_ILL;
            state_d = S_DONE;
          end
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (kind == K_LDI) ? S_DONE : S_T6;
      S_T6: begin
        if (kind == K_ST)  state_d = S_T7;
        else if (mem_ready) state_d = S_T7;
        else if (expired)   state_d = S_FAULT;
      end
      S_T7: begin
        if (kind == K_LD)   state_d = S_DONE;
        else if (mem_ready) state_d = S_DONE;
        else if (expired)   state_d = S_FAULT;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // PCin only on the first cycle of the fetch wait
  assign first_d = (state_d == S_T1) && (state != S_T1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      kind  <= K_LD;
      ctl_q <= '0;
    end else begin
      state <= state_d;
      kind  <= kind_d;
      ctl_q <= ctl_decode(state_d, kind_d, first_d);
    end
  end

  assign PCout    = ctl_q.pc_out;
  assign PCin     = ctl_q.pc_in;
  assign IncPC    = ctl_q.inc_pc;
  assign MARin    = ctl_q.mar_in;
  assign MDRin    = ctl_q.mdr_in;
  assign MDRout   = ctl_q.mdr_out;
  assign read     = ctl_q.read;
  assign write    = ctl_q.write;
  assign IRin     = ctl_q.ir_in;
  assign Yin      = ctl_q.y_in;
  assign Zlowin   = ctl_q.zlow_in;
  assign Zlowout  = ctl_q.zlow_out;
  assign Gra      = ctl_q.gra;
  assign Grb      = ctl_q.grb;
  assign Grc      = 1'b0;
  assign Rin      = ctl_q.r_in;
  assign Rout     = ctl_q.r_out;
  assign BAout    = ctl_q.ba_out;
  assign Cout     = ctl_q.c_out;
  assign mdr_read = ctl_q.mdr_read;
  assign alu_op   = ctl_q.alu_op;
  assign busy     = ctl_q.busy;
  assign done     = ctl_q.done;
  assign illegal  = ctl_q.illegal;
  assign fault    = ctl_q.fault;

endmodule

// File: tb/tb_mem_op_control.sv
// Bench for mem_op_control: per-cycle schedule model
// built from the microstep table, random waits and ir noise.
module tb_mem_op_control;
  import mem_op_pkg::*;

  localparam int DATA_W   = 32;
  localparam int OPC_W    = 5;
  localparam int WAIT_MAX = 15;

  typedef logic [28:0] vec_t;

  localparam vec_t PCOUT   = vec_t'(1) << 28;
  localparam vec_t PCIN    = vec_t'(1) << 27;
  localparam vec_t INCPC   = vec_t'(1) << 26;
  localparam vec_t MARIN   = vec_t'(1) << 25;
  localparam vec_t MDRIN   = vec_t'(1) << 24;
  localparam vec_t MDROUT  = vec_t'(1) << 23;
  localparam vec_t READ    = vec_t'(1) << 22;
  localparam vec_t WRITE   = vec_t'(1) << 21;
  localparam vec_t IRIN    = vec_t'(1) << 20;
  localparam vec_t YIN     = vec_t'(1) << 19;
  localparam vec_t ZLOWIN  = vec_t'(1) << 18;
  localparam vec_t ZLOWOUT = vec_t'(1) << 17;
  localparam vec_t GRA     = vec_t'(1) << 16;
  localparam vec_t GRB     = vec_t'(1) << 15;
  localparam vec_t RIN     = vec_t'(1) << 13;
  localparam vec_t ROUT    = vec_t'(1) << 12;
  localparam vec_t BAOUT   = vec_t'(1) << 11;
  localparam vec_t COUT    = vec_t'(1) << 10;
  localparam vec_t MEMSRC  = vec_t'(MDR_MEM) << 8;
  localparam vec_t ALUADD  = vec_t'(ALU_ADD) << 4;
  localparam vec_t BUSY    = vec_t'(1) << 3;
  localparam vec_t DONE    = vec_t'(1) << 2;
  localparam vec_t ILLEGAL = vec_t'(1) << 1;
  localparam vec_t FLT     = vec_t'(1);

  logic clk = 1'b0;
  logic reset, start, mem_ready;
  logic [DATA_W-1:0] ir;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout;
  logic read, write, IRin, Yin, Zlowin, Zlowout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [1:0] mdr_read;
  logic [3:0] alu_op;
  logic busy, done, illegal, fault;

  always #5 clk = ~clk;

  mem_op_control #(
    .DATA_W(DATA_W), .OPC_W(OPC_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ir(ir),
    .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .read(read), .write(write), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zlowout(Zlowout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .mdr_read(mdr_read), .alu_op(alu_op),
    .busy(busy), .done(done), .illegal(illegal),
    .fault(fault)
  );

  vec_t obs;
  assign obs = {PCout, PCin, IncPC, MARin, MDRin, MDRout,
                read, write, IRin, Yin, Zlowin, Zlowout,
                Gra, Grb, Grc, Rin, Rout, BAout, Cout,
                mdr_read, alu_op, busy, done, illegal, fault};

  int tests = 0;
  int fails = 0;

  vec_t exp_q[$];
  bit   mr_q[$];
  bit   t3_q[$];
  bit   sr_q[$];
  bit   faulted;

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic chk(string tag, vec_t got, vec_t want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic chk_int(string tag, int got, int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic push(vec_t v, bit mr, bit t3, bit sr);
    exp_q.push_back(v);
    mr_q.push_back(mr);
    t3_q.push_back(t3);
    sr_q.push_back(sr);
  endtask

  // w misses then ready; w >= WAIT_MAX means timeout
  task automatic wait_phase(vec_t first, vec_t rest, int w);
    int n;
    n = (w >= WAIT_MAX) ? WAIT_MAX : w + 1;
    for (int i = 0; i < n; i++)
      push((i == 0) ? first : rest, (i == w), 1'b0, 1'b1);
    if (w >= WAIT_MAX) faulted = 1'b1;
  endtask

  task automatic build(input logic [OPC_W-1:0] opc,
                       input int w1, input int w6,
                       input int w7);
    bit ill;
    vec_t t1;
    ill = (opc > 2);
    exp_q.delete();
    mr_q.delete();
    t3_q.delete();
    sr_q.delete();
    faulted = 1'b0;
    t1 = ZLOWOUT | READ | MDRIN | MEMSRC | BUSY;
    push(PCOUT | MARIN | INCPC | ZLOWIN | BUSY, rb(), 0, 1);
    wait_phase(t1 | PCIN, t1, w1);
    if (!faulted) begin
      push(MDROUT | IRIN | BUSY, rb(), 0, 1);
      push(GRB | BAOUT | YIN | BUSY, rb(), 1, 1);
      if (!ill) begin
        push(COUT | ALUADD | ZLOWIN | BUSY, rb(), 0, 1);
        if (opc == 1) begin
          push(ZLOWOUT | GRA | RIN | BUSY, rb(), 0, 1);
        end else begin
          push(ZLOWOUT | MARIN | BUSY, rb(), 0, 1);
          if (opc == 0) begin
            wait_phase(READ | MDRIN | MEMSRC | BUSY,
                       READ | MDRIN | MEMSRC | BUSY, w6);
            if (!faulted)
              push(MDROUT | GRA | RIN | BUSY, rb(), 0, 1);
          end else begin
            push(GRA | ROUT | MDRIN | BUSY, rb(), 0, 1);
            wait_phase(WRITE | BUSY, WRITE | BUSY, w7);
          end
        end
      end
    end
    if (faulted) begin
      repeat (4) push(FLT, rb(), 0, 1);
    end else begin
      push(DONE | BUSY | (ill ? ILLEGAL : vec_t'(0)),
           rb(), 0, 1);
      push(vec_t'(0), rb(), 0, 0);
    end
  endtask

  task automatic run(input logic [OPC_W-1:0] opc,
                     input int w1, input int w6,
                     input int w7, input int abort);
    int  lat;
    int  done_at;
    bit  resv;
    bit  aborted;
    build(opc, w1, w6, w7);
    if (opc == 0)      lat = 9 + w1 + w6;
    else if (opc == 1) lat = 7 + w1;
    else if (opc == 2) lat = 9 + w1 + w7;
    else               lat = 5 + w1;
    @(negedge clk);
    chk("idle", obs, vec_t'(0));
    start     = 1'b1;
    ir        = DATA_W'($urandom);
    mem_ready = rb();
    done_at   = -1;
    resv      = 1'b0;
    aborted   = 1'b0;
    for (int k = 0; k < exp_q.size() && !aborted; k++) begin
      @(negedge clk);
      chk($sformatf("op%0d cyc%0d", opc, k + 1), obs, exp_q[k]);
      if (done && done_at < 0) done_at = k + 1;
      if (Grc || mdr_read === MDR_IMM) resv = 1'b1;
      mem_ready = mr_q[k];
      ir = DATA_W'($urandom);
      if (t3_q[k]) ir[DATA_W-1 -: OPC_W] = opc;
      start = sr_q[k] ? rb() : 1'b0;
      if (k == abort) begin
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("abort_reset", obs, vec_t'(0));
        reset   = 1'b1;
        aborted = 1'b1;
      end
    end
    chk_int("reserved", int'(resv), 0);
    if (!aborted && !faulted) chk_int("latency", done_at, lat);
    if (!aborted && faulted) begin
      chk_int("no_done", done_at, -1);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      chk("fault_reset", obs, vec_t'(0));
      reset = 1'b1;
    end
  endtask

  function automatic int rw();
    if ($urandom_range(0, 9) == 0)
      return int'($urandom_range(15, 18));
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    logic [OPC_W-1:0] op;
    int ab;
    reset     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    ir        = '0;
    repeat (3) @(negedge clk);
    chk("reset", obs, vec_t'(0));
    reset = 1'b1;

    run(5'd0, 0, 0, 0, -1);
    run(5'd1, 0, 0, 0, -1);
    run(5'd2, 0, 0, 0, -1);
    run(5'd2, 0, 0, 3, -1);
    run(5'd31, 0, 0, 0, -1);
    run(5'd0, 15, 0, 0, -1);
    run(5'd0, 0, 8, 0, 8);
    run(5'd0, 0, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      op = OPC_W'($urandom_range(0, 3));
      if (op == 3) op = OPC_W'($urandom_range(3, 31));
      ab = ($urandom_range(0, 7) == 0)
         ? int'($urandom_range(0, 10)) : -1;
      run(op, rw(), rw(), rw(), ab);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_op_control.md
MEM_OP_CONTROL -- requirements
Module: mem_op_control

Interface
REQ-001 Parameter DATA_W, 32, datapath and IR width.
REQ-002 Parameter OPC_W, 5, opcode field width, taken from ir[DATA_W-1 -: OPC_W].
REQ-003 Parameter WAIT_MAX, 15, maximum memory wait cycles per access before fault.
REQ-004 Ports: clk in 1, single clock, all state on rising edge; reset in 1, synchronous, active-low.
REQ-005 Ports: start in 1, begin one instruction; ir in DATA_W, IR contents; mem_ready in 1, memory access complete.
REQ-006 Ports, all out 1: PCout, PCin, IncPC, MARin, MDRin, MDRout, read, write, IRin, Yin, Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout.
REQ-007 Ports: mdr_read out 2, MDR source (00 bus, 01 memory, 10 immediate); alu_op out 4, ALU control.
REQ-008 Ports, all out 1: busy, instruction in progress; done, one-cycle completion pulse; illegal, one-cycle pulse with done on unknown opcode; fault, sticky memory timeout flag.

Function
REQ-009 States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, DONE, FAULT; control outputs SHALL be a pure decode of the registered state (Moore).
REQ-010 IDLE: all outputs 0; start=1 -> T0 next edge; start ignored in every other state.
REQ-011 T0: PCout, MARin, IncPC, Zlowin -> T1.
REQ-012 T1: Zlowout, PCin (first T1 cycle only), read, MDRin, mdr_read=01; hold T1 while mem_ready=0; -> T2 on the edge where mem_ready=1.
REQ-013 T2: MDRout, IRin -> T3.
REQ-014 T3 decode: opcode 0 (ld), 1 (ldi), 2 (st): Grb, BAout, Yin -> T4; any other opcode -> DONE with illegal.
REQ-015 T4: Cout, alu_op=4'd2 (ADD), Zlowin -> T5.
REQ-016 T5: ldi: Zlowout, Gra, Rin -> DONE; ld/st: Zlowout, MARin -> T6.
REQ-017 T6: ld: read, MDRin, mdr_read=01, held until mem_ready=1 -> T7; st: Gra, Rout, MDRin, mdr_read=00 -> T7.
REQ-018 T7: ld: MDRout, Gra, Rin -> DONE; st: write, held until mem_ready=1 -> DONE.
REQ-019 DONE: done=1 (plus illegal if flagged) for exactly one cycle -> IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE and FAULT.
REQ-021 Wait counter SHALL clear on entry to T1, T6 (ld) and T7 (st) and increment each cycle mem_ready=0 in those states; reaching WAIT_MAX -> FAULT.
REQ-022 FAULT: all control outputs 0, fault=1, busy=0; exit only by reset.
REQ-023 mem_ready outside wait states SHALL be ignored; mem_ready=1 on the first wait cycle gives zero wait-state latency.
REQ-024 Latency with no wait states: ld 9, ldi 7, st 9 cycles from start sample to done pulse, inclusive.
REQ-025 Opcode SHALL be captured from ir in T3 only; ir changes at other times SHALL have no effect.
REQ-026 Grc and mdr_read=10 SHALL never be asserted by this block; the ports are reserved for later opcodes.

Reset
REQ-027 reset=0 at a clock edge SHALL force IDLE, clear the wait counter and fault, and drive all outputs to 0 by the following cycle, from any state, including mid-wait.
REQ-028 No output SHALL depend on reset combinationally.

Structure
REQ-029 Package mem_op_pkg SHALL hold the state enumeration, opcode constants (LD=0, LDI=1, ST=2), mdr_read encodings and ALU_ADD=4'd2.
REQ-030 Sub-module mem_wait_timer (clear, enable, WAIT_MAX parameter, expired output) SHALL implement the wait counter; all else in one FSM.

Verification
REQ-031 ld, ir opcode 0, mem_ready tied 1, start pulse -> done in cycle 9, Rin with Gra in T7, illegal=0.
REQ-032 ldi -> done in cycle 7; MARin high only in T0; no read in T5-T7.
REQ-033 st with mem_ready low 3 cycles in T7 -> write held 4 cycles, done 3 cycles later than the no-wait case.
REQ-034 opcode 31 -> done and illegal pulse together in cycle 5, then IDLE.
REQ-035 mem_ready held 0 in T1, WAIT_MAX=15 -> FAULT after 15 wait cycles, fault=1 and busy=0 until reset.
REQ-036 reset=0 asserted during the T6 wait -> IDLE and all outputs 0 next cycle; start then runs a normal ld.
